// File: rtl/fma_normalizer_pkg.sv
// Shared types and constants for the FMA normalizer stage.
// Sized for a 32-bit adder sum feeding a single-precision accumulator.
package fma_normalizer_pkg;

  localparam int SUM_W    = 32;
  localparam int FRAC_POS = 30;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int EXP_MAX  = 254;
  localparam int LZC_W    = $clog2(SUM_W) + 1;
  localparam int SEXP_W   = EXP_W + 2;

  typedef logic [SUM_W-1:0]         sum_t;
  typedef logic [EXP_W-1:0]         exp_t;
  typedef logic [MANT_W-1:0]        mant_t;
  typedef logic [LZC_W-1:0]         lzc_t;
  typedef logic signed [SEXP_W-1:0] sexp_t;

  typedef struct packed {
    logic  sign;
    exp_t  exp;
    mant_t mant;
  } acc_t;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic uf;
  } flags_t;

  typedef struct packed {
    logic sign;
    sum_t mag;
    lzc_t lzc;
    exp_t exp;
  } s1_t;

endpackage

// File: rtl/fma_normalizer_lzc.sv
// Leading-zero counter for the normalizer magnitude.
// Yields W when the input is all zeros.
module lzc_count #(
  parameter  int W  = 32,
  localparam int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_cnt
);

  // highest set bit wins; scan upward so later hits override
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fma_normalizer.sv
// Normalize, round-to-nearest-even and flag the FMA adder sum.
// Two registered stages with valid/ready back-pressure.
module fma_normalizer
  import fma_normalizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_uf
);

  logic   r_s1_valid;
  logic   r_s2_valid;
  s1_t    r_s1;
  acc_t   r_out;
  flags_t r_flg;

  logic   w_s1_adv;
  logic   w_s2_adv;
  logic   w_sign;
  sum_t   w_mag;
  lzc_t   w_lzc;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_sign = in_sum[SUM_W-1];
  assign w_mag  = w_sign ? sum_t'(-in_sum) : in_sum;

  lzc_count #(.W(SUM_W)) u_lzc (
    .i_data (w_mag),
    .o_cnt  (w_lzc)
  );

  lzc_t          w_p;
  sexp_t         w_e;
  sum_t          w_norm;
  mant_t         w_frac;
  logic          w_guard;
  logic          w_sticky;
  logic          w_inc;
  logic [MANT_W:0] w_rnd;
  sexp_t         w_e_rnd;
  logic          w_is_zero;
  logic          w_is_ovf;
  logic          w_is_uf;
  acc_t          w_res;
  flags_t        w_flg;

  assign w_p      = lzc_t'(SUM_W - 1) - r_s1.lzc;
  assign w_e      = sexp_t'(r_s1.exp) + sexp_t'(w_p)
                  - sexp_t'(FRAC_POS);
  assign w_norm   = r_s1.mag << r_s1.lzc;
  assign w_frac   = w_norm[SUM_W-2 -: MANT_W];
  assign w_guard  = w_norm[SUM_W-2-MANT_W];
  assign w_sticky = |w_norm[SUM_W-3-MANT_W:0];
  assign w_inc    = w_guard & (w_sticky | w_frac[0]);
  assign w_rnd    = {1'b0, w_frac} + (MANT_W+1)'(w_inc);
  assign w_e_rnd  = w_e + sexp_t'(w_rnd[MANT_W]);

  // hidden bit absent after alignment means the magnitude was zero
  assign w_is_zero = ~w_norm[SUM_W-1];
  assign w_is_ovf  = !w_is_zero && (w_e_rnd > sexp_t'(EXP_MAX));
  assign w_is_uf   = !w_is_zero && (w_e_rnd < sexp_t'(1));

  // select the special-case or normal result for stage 2
  always_comb begin
    w_res = '0;
    w_flg = '0;
    unique case (1'b1)
      w_is_zero: begin
        w_flg.zero = 1'b1;
      end
      w_is_ovf: begin
        w_res.sign = r_s1.sign;
        w_res.exp  = exp_t'(EXP_MAX);
        w_res.mant = '1;
        w_flg.ovf  = 1'b1;
      end
      w_is_uf: begin
        w_res.sign = r_s1.sign;
        w_flg.uf   = 1'b1;
      end
      default: begin
        w_res.sign = r_s1.sign;
        w_res.exp  = exp_t'(w_e_rnd);
        w_res.mant = w_rnd[MANT_W-1:0];
      end
    endcase
  end

  // stage 1: sign, magnitude, leading zeros, exponent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1.sign <= w_sign;
        r_s1.mag  <= w_mag;
        r_s1.lzc  <= w_lzc;
        r_s1.exp  <= in_exp;
      end
    end
  end

  // stage 2: rounded result and flags, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_flg      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_res;
        r_flg <= w_flg;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sign  = r_out.sign;
  assign out_exp   = r_out.exp;
  assign out_mant  = r_out.mant;
  assign out_zero  = r_flg.zero;
  assign out_ovf   = r_flg.ovf;
  assign out_uf    = r_flg.uf;

endmodule

// File: tb/tb_fma_normalizer.sv
// Testbench for fma_normalizer: arithmetic model plus directed vectors.
// Covers rounding, specials, back-pressure and async reset.
module tb_fma_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_sum = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
  logic        out_zero;
  logic        out_ovf;
  logic        out_uf;

  fma_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_uf    (out_uf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        z;
    logic        o;
    logic        u;
  } res_t;

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  ex;
    res_t        exp;
  } vec_t;

  res_t w_dut;
  assign w_dut = {out_sign, out_exp, out_mant,
                  out_zero, out_ovf, out_uf};

  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   n_rdy_low = 0;
  res_t q[$];

  // value = sum * 2^(exp-30-bias); round mag to 24 significant bits
  function automatic res_t model(logic [31:0] sum, logic [7:0] ex);
    res_t   r;
    longint mag, qv, rem, half;
    int     p, sh, e;
    r = '0;
    r.s = sum[31];
    if (sum[31]) mag = (longint'(1) << 32) - longint'(sum);
    else mag = longint'(sum);
    if (mag == 0) begin
      r = '0;
      r.z = 1'b1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    sh = p - 23;
    if (sh > 0) begin
      qv = mag >> sh;
      rem = mag - (qv << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && qv[0])) qv = qv + 1;
    end else begin
      qv = mag << (-sh);
    end
    e = int'(ex) + p - 30;
    if (qv == (longint'(1) << 24)) begin
      qv = longint'(1) << 23;
      e = e + 1;
    end
    if (e > 254) begin
      r.e = 8'd254;
      r.m = '1;
      r.o = 1'b1;
    end else if (e < 1) begin
      r.e = 8'd0;
      r.m = '0;
      r.u = 1'b1;
    end else begin
      r.e = 8'(e);
      r.m = 23'(qv - (longint'(1) << 23));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // scoreboard compare, stall stability and in_ready rule
  res_t prev;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", w_dut, prev);
      end
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (!in_ready) n_rdy_low++;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("out_expected", q.size(), 1);
        end else begin
          chk("out_data", w_dut, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = w_dut;
      if (in_valid && in_ready) q.push_back(model(in_sum, in_exp));
    end
  end

  // out_ready pattern 1,0,0,1 during the back-pressure stream
  bit       bp_on = 1'b0;
  int       bp_k = 0;
  logic [3:0] bp_pat = 4'b1001;
  always @(posedge clk) begin
    if (bp_on) begin
      #1 out_ready = bp_pat[bp_k % 4];
      bp_k++;
    end
  end

  // present one input at posedge+1 and hold until accepted
  task automatic send(input logic [31:0] s, input logic [7:0] e);
    int n;
    in_sum = s;
    in_exp = e;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, q.size(), 0);
  endtask

  vec_t        vt[11];
  logic [31:0] bs[8];
  logic [7:0]  be[8];
  int          n0;

  initial begin
    vt[0]  = '{32'h40000000, 8'd127, '{1'b0, 8'd127, 23'h000000, 1'b0, 1'b0, 1'b0}};
    vt[1]  = '{32'hA0000000, 8'd127, '{1'b1, 8'd127, 23'h400000, 1'b0, 1'b0, 1'b0}};
    vt[2]  = '{32'h40000040, 8'd127, '{1'b0, 8'd127, 23'h000000, 1'b0, 1'b0, 1'b0}};
    vt[3]  = '{32'h400000C0, 8'd127, '{1'b0, 8'd127, 23'h000002, 1'b0, 1'b0, 1'b0}};
    vt[4]  = '{32'h7FFFFFC0, 8'd127, '{1'b0, 8'd128, 23'h000000, 1'b0, 1'b0, 1'b0}};
    vt[5]  = '{32'h7FFFFFC0, 8'd254, '{1'b0, 8'd254, 23'h7FFFFF, 1'b0, 1'b1, 1'b0}};
    vt[6]  = '{32'h80000000, 8'd127, '{1'b1, 8'd128, 23'h000000, 1'b0, 1'b0, 1'b0}};
    vt[7]  = '{32'h00000000, 8'd127, '{1'b0, 8'd0,   23'h000000, 1'b1, 1'b0, 1'b0}};
    vt[8]  = '{32'h20000000, 8'd1,   '{1'b0, 8'd0,   23'h000000, 1'b0, 1'b0, 1'b1}};
    vt[9]  = '{32'hFFFFFFFF, 8'd127, '{1'b1, 8'd97,  23'h000000, 1'b0, 1'b0, 1'b0}};
    vt[10] = '{32'h00000003, 8'd50,  '{1'b0, 8'd21,  23'h400000, 1'b0, 1'b0, 1'b0}};

    bs = '{32'h40000000, 32'hA0000000, 32'h400000C0, 32'h7FFFFFC0,
           32'h00000001, 32'hC0000001, 32'h12345678, 32'hFFFFFF00};
    be = '{8'd127, 8'd100, 8'd127, 8'd200, 8'd60, 8'd127, 8'd90, 8'd130};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", w_dut, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("model%0d", i), model(vt[i].sum, vt[i].ex), vt[i].exp);
      send(vt[i].sum, vt[i].ex);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("lat_early%0d", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("lat%0d", i), out_valid, 1);
      chk($sformatf("dir%0d", i), w_dut, vt[i].exp);
      @(posedge clk);
      #1;
    end

    n0 = n_out;
    n_rdy_low = 0;
    bp_on = 1'b1;
    for (int i = 0; i < 8; i++) send(bs[i], be[i]);
    in_valid = 1'b0;
    drain("bp_drain");
    chk("bp_count", n_out - n0, 8);
    chk("bp_ready_dropped", n_rdy_low > 0, 1);
    bp_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b0;

    send(32'h40000000, 8'd127);
    send(32'hA0000000, 8'd127);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("inflight_count", q.size(), 2);
    chk("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", w_dut, 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n0 = n_out;
    send(32'h7FFFFFC0, 8'd127);
    in_valid = 1'b0;
    drain("post_rst_drain");
    chk("post_rst_count", n_out - n0, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
